avst_tx_pkt_buffer: RTL
=======================

Name: avst_tx_pkt_buffer

Overview:
Parametrised Avalon-ST packet buffer between the DMA egress stream and the 10G MAC avalon_st_tx interface.
- Store-and-forward mode: the MAC never sees a mid-packet underrun.
- Errored and oversize packets are discarded before they reach the MAC.
- Cut-through mode is kept for low-latency use.
- Width and depth are generic, so the same block serves 64-bit 10G and wider future MACs.

Parameters:
DATA_W, 64, beat width in bits (multiple of 8)
EMPTY_W, 3, empty field width, equals log2(DATA_W/8)
DEPTH, 512, buffer depth in beats (power of 2, >= 16)
STORE_FWD, 1, 1 = store-and-forward, 0 = cut-through
DROP_ERR, 1, 1 = discard packets with error on eop (STORE_FWD only)

Ports:
tx_156_25_clk  in  1  sole clock
tx_rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream beat valid
in_ready  out  1  buffer can accept beat
in_data  in  DATA_W  beat data
in_startofpacket  in  1  first beat
in_endofpacket  in  1  last beat
in_empty  in  EMPTY_W  unused bytes on eop beat
in_error  in  1  packet error, sampled on eop beat
out_valid  out  1  beat to MAC valid
out_ready  in  1  MAC ready
out_data  out  DATA_W  beat data
out_startofpacket  out  1  first beat
out_endofpacket  out  1  last beat
out_empty  out  EMPTY_W  unused bytes
out_error  out  1  error flag (cut-through passthrough)
fill_level  out  log2(DEPTH)+1  beats stored, committed plus uncommitted
pkt_count  out  32  packets committed, wrapping
drop_count  out  32  packets discarded (error, oversize, protocol), wrapping

Behaviour:
- Reset (async, tx_rst=1): all pointers 0; write FSM in IDLE; in_ready=0 during reset, 1 from the first cycle after release; out_valid=0; out_* data fields 0; fill_level, pkt_count, drop_count = 0.
- Storage: DEPTH x (DATA_W+EMPTY_W+3) RAM with one-cycle read latency and a 1-entry output register.
- Pointers: wr_ptr, commit_ptr and rd_ptr are each log2(DEPTH)+1 bits, wrapping naturally. Full when wr_ptr-rd_ptr==DEPTH. Readable when rd_ptr!=commit_ptr.
- Accept: beat accepted when in_valid && in_ready. in_ready = !full, except in DISCARD, where in_ready=1.
- Write FSM:
  - IDLE: accepted beat with sop goes to WR; an sop+eop single beat commits directly. Accepted beat without sop is discarded, goes to DISCARD, drop_count+1 once.
  - WR, accepted beat with eop:
    - if STORE_FWD && DROP_ERR && in_error: wr_ptr rewinds to commit_ptr, drop_count+1.
    - otherwise: commit_ptr=wr_ptr+1, pkt_count+1.
    - both cases return to IDLE.
  - WR, accepted beat with sop (missing eop): rewind to commit_ptr, drop_count+1, the new beat starts a fresh packet, stay in WR.
  - WR, full while commit_ptr==rd_ptr (packet > DEPTH): rewind, drop_count+1, go to DISCARD.
  - DISCARD: sink beats until an accepted eop, then IDLE. An sop in DISCARD restarts the packet in WR.
- Cut-through (STORE_FWD=0):
  - commit_ptr tracks wr_ptr every accepted beat.
  - No rewinds; in_error is stored and presented on out_error.
  - pkt_count increments on eop; oversize rule disabled.
- Read side:
  - Output register loads when empty or on out_valid && out_ready, if readable.
  - out_valid and out_* stay stable until out_ready.
  - Back-to-back beats are sustained at 1 beat/cycle.
- Latency, STORE_FWD: eop accepted at cycle N gives out_valid with sop at N+2 if the buffer was empty. Cut-through: beat at N is visible at N+2.
- Simultaneous accept and read of the same slot is legal. Full and read in the same cycle frees one slot next cycle; in_ready is not combinationally dependent on out_ready.
- fill_level = wr_ptr - rd_ptr, counting only beats not yet loaded into the output register.
- Mid-operation reset clears everything. A packet partly delivered is truncated with no eop; the MAC handles this.

Test Plan:
- Single 8-beat packet, empty=3 on eop, out_ready=1 -> out_valid first at eop+2 cycles; 8 beats identical incl. empty=3; pkt_count=1.
- 4-beat packet with in_error=1 on eop (STORE_FWD=1, DROP_ERR=1), then a clean 2-beat packet -> only the 2-beat packet appears; drop_count=1, pkt_count=1.
- DEPTH=16, 20-beat packet -> in_ready held 1 after overflow, packet discarded, drop_count=1. A following 3-beat packet is delivered intact.
- Fill buffer with 4-beat packets while out_ready=0 -> in_ready falls when fill_level=DEPTH. Toggle out_ready 1-of-3 -> no beat lost or duplicated; order preserved.
- sop, 2 beats, then a new sop without eop -> first fragment dropped (drop_count=1); second packet delivered complete.
- STORE_FWD=0, 6-beat packet, error=1 on eop -> first beat out at +2 cycles; out_error=1 on eop beat; drop_count=0.

Source files
------------

// File: rtl/avst_tx_pkt_buffer.sv
// Avalon-ST packet buffer feeding the 10G MAC tx stream. Store-and-forward mode holds each
// packet until its eop commits it; errored, oversize and malformed packets never reach the MAC.
module avst_tx_pkt_buffer #(
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int DEPTH     = 512,
  parameter int STORE_FWD = 1,
  parameter int DROP_ERR  = 1
) (
  input  logic                       tx_156_25_clk,
  input  logic                       tx_rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_startofpacket,
  input  logic                       in_endofpacket,
  input  logic [EMPTY_W-1:0]         in_empty,
  input  logic                       in_error,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_startofpacket,
  output logic                       out_endofpacket,
  output logic [EMPTY_W-1:0]         out_empty,
  output logic                       out_error,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [31:0]                pkt_count,
  output logic [31:0]                drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE = PW'(1);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [EMPTY_W-1:0] empty;
    logic               sop;
    logic               eop;
    logic               err;
  } beat_t;

  typedef enum logic [1:0] {IDLE, WR, DISCARD} state_t;

  state_t        state, state_n;
  logic [PW-1:0] wr_ptr, wr_n, commit_ptr, commit_n, rd_ptr, waddr;
  logic          full, readable, accept, keep, we, ld, pkt_inc;
  logic [1:0]    drop_inc;
  beat_t         mem [DEPTH];
  beat_t         wbeat, q;

  assign full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign readable = rd_ptr != commit_ptr;
  assign in_ready = !tx_rst && (state == DISCARD || !full);
  assign accept   = in_valid && in_ready;
  // Outside WR only an sop beat is worth storing; a fresh sop always restarts at the commit point.
  assign keep     = in_startofpacket || state == WR;
  assign waddr    = in_startofpacket ? commit_ptr : wr_ptr;
  assign we       = accept && keep;
  assign wbeat    = {in_data, in_empty, in_startofpacket, in_endofpacket, in_error};

  always_comb begin
    state_n  = state;
    wr_n     = wr_ptr;
    commit_n = commit_ptr;
    pkt_inc  = 1'b0;
    drop_inc = 2'd0;
    if (accept) begin
      if (keep) begin
        wr_n    = waddr + ONE;
        state_n = WR;
        if (STORE_FWD != 0 && state == WR && in_startofpacket) drop_inc = 2'd1;
        if (STORE_FWD == 0) commit_n = waddr + ONE;
        if (in_endofpacket) begin
          state_n = IDLE;
          if (STORE_FWD != 0 && DROP_ERR != 0 && in_error) begin
            wr_n     = commit_ptr;
            drop_inc = drop_inc + 2'd1;
          end else begin
            commit_n = waddr + ONE;
            pkt_inc  = 1'b1;
          end
        end
      end else begin
        state_n = in_endofpacket ? IDLE : DISCARD;
        if (state == IDLE) drop_inc = 2'd1;
      end
    end else if (STORE_FWD != 0 && state == WR && full && commit_ptr == rd_ptr) begin
      // The open packet alone fills the buffer and can never commit.
      wr_n     = commit_ptr;
      drop_inc = 2'd1;
      state_n  = DISCARD;
    end
  end

  always_ff @(posedge tx_156_25_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_n;
      commit_ptr <= commit_n;
      pkt_count  <= pkt_count + 32'(pkt_inc);
      drop_count <= drop_count + 32'(drop_inc);
    end
  end

  always_ff @(posedge tx_156_25_clk) begin
    if (we) mem[waddr[AW-1:0]] <= wbeat;
  end

  // The RAM read register doubles as the output stage, giving two-cycle commit-to-valid latency.
  assign ld = readable && (!out_valid || out_ready);

  always_ff @(posedge tx_156_25_clk or posedge tx_rst) begin
    if (tx_rst) begin
      out_valid <= 1'b0;
      rd_ptr    <= '0;
      q         <= '0;
    end else if (ld) begin
      q         <= mem[rd_ptr[AW-1:0]];
      out_valid <= 1'b1;
      rd_ptr    <= rd_ptr + ONE;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data          = q.data;
  assign out_empty         = q.empty;
  assign out_startofpacket = q.sop;
  assign out_endofpacket   = q.eop;
  assign out_error         = q.err;
  assign fill_level        = wr_ptr - rd_ptr;
endmodule
